memory_banked: RTL and testbench
================================

Name: memory_banked

Overview:
- Parametrised successor to the two-lane (even/odd) byte memory subsystem.
- Provides BANKS independent byte lanes, each with its own read port and write port. Each lane decodes RAM, ROM and unmapped regions.
- Read latency is configurable, with a valid pipeline, optional write-to-read bypass and a ROM-write error flag.
- Sits between the CPU datapath and the on-chip RAM/ROM banks.

Parameters:
- BANKS, 2, number of byte lanes; power of two, 1..8. Lane b serves byte addresses with addr % BANKS == b.
- RAMADDRBITS, 10, address bits per RAM bank; RAM region is byte addresses [0, BANKS*2**RAMADDRBITS).
- ROMSIZE, 2048, ROM size in bytes; multiple of BANKS.
- ROMBASE, 16'h4000, first ROM byte address; multiple of BANKS; must be >= the RAM region size.
- RDLAT, 1, read latency in cycles, 1 or 2. With 2, an output register is added after the bank array.
- BYPASS, 0, if 1 a same-cycle same-address write on a lane forwards its data to that lane's read.
- LA (localparam), 16 - $clog2(BANKS), lane address width.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- read_addr, input, BANKS x LA, per-lane word address; byte address = {read_addr[b], b}.
- read_req, input, BANKS, per-lane read request.
- read_data, output, BANKS x 8, per-lane read data.
- read_valid, output, BANKS, per-lane read data valid.
- write_addr, input, BANKS x LA, per-lane write word address.
- write_data, input, BANKS x 8, per-lane write data.
- write_en, input, BANKS, per-lane write enable.
- rom_write_err, output, BANKS, one-cycle pulse: a write was attempted into the ROM region.

Behaviour:
- Reset: read_valid=0, read_data=8'h00, rom_write_err=0, all pipeline stages cleared. RAM contents are preserved. Writes and reads presented while reset=1 are ignored and produce no valid.
- Region decode, per lane, applied to the full byte address:
  - RAM if addr < BANKS*2**RAMADDRBITS.
  - ROM if ROMBASE <= addr < ROMBASE+ROMSIZE.
  - Otherwise UNMAPPED.
- Read pipeline: a read_req accepted at cycle N asserts read_valid at cycle N+RDLAT, with read_data of that request. The region tag is pipelined alongside and selects the source: RAM bank, ROM bank, or constant 8'hFF for UNMAPPED.
- No request at cycle N gives read_valid=0 at N+RDLAT. read_data then holds its last value and is not cleared.
- Throughput: one read per lane per cycle, back-to-back, with no bubbles.
- Writes:
  - RAM-region write commits at the posedge where write_en=1.
  - ROM-region write is discarded and pulses rom_write_err[b] on the following cycle.
  - UNMAPPED write is silently discarded.
- Read/write to the same lane and same address in the same cycle:
  - BYPASS=0 (read-first): returns old data.
  - BYPASS=1: returns write_data. RAM region only; never for ROM or UNMAPPED.
- A write at cycle N is visible to any read issued at N+1 or later.
- Lanes are fully independent; simultaneous activity on all lanes is legal.
- Address wrap: lane addresses are not incremented internally, so there is no wrap. The top ROM byte (ROMBASE+ROMSIZE-1) decodes as ROM; the next byte decodes as UNMAPPED.
- Reset mid-operation: in-flight reads are dropped, with no read_valid after reset asserts. A write in the same cycle as reset is not committed.
- Elaboration checks: fatal error on illegal BANKS or RDLAT, misaligned ROMBASE/ROMSIZE, or RAM/ROM overlap.

Decomposition:
- Package memory_pkg holds:
  - region_t enum {REG_RAM, REG_ROM, REG_UNMAPPED}.
  - UNMAPPED_DATA = 8'hFF.
  - Function decode_region(byte_addr, BANKS, RAMADDRBITS, ROMBASE, ROMSIZE).
- Sub-module memory_lane: one lane, containing the RAM bank, ROM bank slice, decode, bypass, latency pipeline and error flag. memory_banked instantiates BANKS of them in a generate loop, passing lane index b.
- Existing rom/ram primitives are reused inside memory_lane.

Test Plan:
- RAM write/read, BANKS=2, RDLAT=1: write 8'hA5 to byte 16'h0011 (lane 1, addr 8), read the same at N+1 -> read_valid[1]=1 at N+2 with data A5; read_valid[0] stays 0.
- Region and unmapped decode: read byte 16'h4000 -> ROM image byte 0. Read byte 16'h1000 -> 8'hFF. Read byte 16'h4800 (ROMBASE+ROMSIZE) -> 8'hFF.
- ROM write protect: write 8'h00 to byte 16'h4002 -> rom_write_err[0] pulses for exactly one cycle, and a later read returns the unchanged ROM byte.
- Collision: RAM holds 8'h11 at byte 16'h0020; write 8'h22 to it and read it in the same cycle. BYPASS=0 -> 11; BYPASS=1 -> 22. A following read returns 22 in both cases.
- Latency/throughput, RDLAT=2, BANKS=4: read_req on all lanes for 8 consecutive cycles -> read_valid high on all lanes from cycle 2 through 9, data in order, no gaps.
- Reset mid-stream: reset asserted while 2 reads are in flight (RDLAT=2) -> no read_valid afterwards; all outputs zero during reset; RAM data written before reset reads back intact after it.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and helpers for the banked byte memory: region tags,
// the constant returned for unmapped reads, the address decoder and
// the ROM image contents.
package memory_pkg;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_ROM      = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_t;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

    // ROM image: byte at offset o holds o[7:0] ^ ROM_SEED.
    localparam logic [7:0] ROM_SEED = 8'h3C;

    // Classify a full byte address into RAM, ROM or unmapped space.
    function automatic region_t decode_region(
        input logic [31:0] byte_addr,
        input int          banks,
        input int          ramaddrbits,
        input int          rombase,
        input int          romsize
    );
        logic [31:0] ram_top;
        ram_top = 32'(banks) << ramaddrbits;
        if (byte_addr < ram_top) begin
            return REG_RAM;
        end else if ((byte_addr >= 32'(rombase)) && (byte_addr < 32'(rombase + romsize))) begin
            return REG_ROM;
        end else begin
            return REG_UNMAPPED;
        end
    endfunction

    // ROM contents indexed by byte offset from ROMBASE (low 8 bits suffice).
    function automatic logic [7:0] rom_image(input logic [7:0] offset);
        return offset ^ ROM_SEED;
    endfunction

endpackage

// File: rtl/memory_lane.sv
// One byte lane: RAM bank, ROM slice, region decode, optional
// write-to-read bypass, 1- or 2-cycle read pipeline and ROM write flag.
//
// Handshake: a read is accepted on every posedge where i_rd_req=1 and
// reset=0; o_rd_valid rises exactly RDLAT cycles later for one cycle with
// that read's data. There is no backpressure. o_rd_data holds its last
// value while o_rd_valid=0.
module memory_lane
    import memory_pkg::*;
#(
    parameter  int BANKS       = 2,
    parameter  int RAMADDRBITS = 10,
    parameter  int ROMSIZE     = 2048,
    parameter  int ROMBASE     = 'h4000,
    parameter  int RDLAT       = 1,
    parameter  int BYPASS      = 0,
    parameter  int LANE        = 0,
    localparam int LA          = 16 - $clog2(BANKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [LA-1:0] i_rd_addr,
    input  logic          i_rd_req,
    output logic [7:0]    o_rd_data,
    output logic          o_rd_valid,
    input  logic [LA-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_wr_en,
    output logic          o_rom_write_err
);

    localparam int RAM_WORDS = 2 ** RAMADDRBITS;

    logic [7:0]             r_mem [RAM_WORDS];
    logic [31:0]            w_rd_byte;
    logic [31:0]            w_wr_byte;
    region_t                w_rd_region;
    region_t                w_wr_region;
    logic [RAMADDRBITS-1:0] w_rd_idx;
    logic [RAMADDRBITS-1:0] w_wr_idx;
    logic [7:0]             w_rom_off;
    logic                   w_bypass_hit;

    logic                   r_s1_valid;
    region_t                r_s1_region;
    logic [7:0]             r_s1_ram;
    logic [7:0]             r_s1_rom;
    logic [7:0]             w_s1_data;
    logic                   r_err;

    // Lane b owns byte addresses lane_addr*BANKS + b.
    assign w_rd_byte   = 32'(i_rd_addr) * 32'(BANKS) + 32'(LANE);
    assign w_wr_byte   = 32'(i_wr_addr) * 32'(BANKS) + 32'(LANE);
    assign w_rd_region = decode_region(w_rd_byte, BANKS, RAMADDRBITS, ROMBASE, ROMSIZE);
    assign w_wr_region = decode_region(w_wr_byte, BANKS, RAMADDRBITS, ROMBASE, ROMSIZE);
    assign w_rd_idx    = i_rd_addr[RAMADDRBITS-1:0];
    assign w_wr_idx    = i_wr_addr[RAMADDRBITS-1:0];
    assign w_rom_off   = 8'(w_rd_byte - 32'(ROMBASE));

    // Forwarding only applies when both sides hit RAM at the same word.
    assign w_bypass_hit = (BYPASS != 0) && i_wr_en
                          && (w_wr_region == REG_RAM) && (w_rd_region == REG_RAM)
                          && (i_wr_addr == i_rd_addr);

    // RAM bank: commit RAM-region writes; no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (!reset && i_wr_en && (w_wr_region == REG_RAM)) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
    end

    // Stage 1: capture bank bytes and region tag for each accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_region <= REG_RAM;
            r_s1_ram    <= 8'h00;
            r_s1_rom    <= 8'h00;
        end else begin
            r_s1_valid <= i_rd_req;
            if (i_rd_req) begin
                r_s1_region <= w_rd_region;
                r_s1_ram    <= w_bypass_hit ? i_wr_data : r_mem[w_rd_idx];
                r_s1_rom    <= rom_image(w_rom_off);
            end
        end
    end

    // Region tag picks the data source for the captured read.
    always_comb begin
        w_s1_data = UNMAPPED_DATA;
        case (r_s1_region)
            REG_RAM: w_s1_data = r_s1_ram;
            REG_ROM: w_s1_data = r_s1_rom;
            default: w_s1_data = UNMAPPED_DATA;
        endcase
    end

    // ROM write flag: pulse one cycle after a write aimed at ROM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= i_wr_en && (w_wr_region == REG_ROM);
        end
    end

    assign o_rom_write_err = r_err;

    if (RDLAT == 2) begin : g_lat2
        logic       r_s2_valid;
        logic [7:0] r_s2_data;

        // Output register stage; data only advances with a valid read.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= 8'h00;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_s1_data;
                end
            end
        end

        assign o_rd_valid = r_s2_valid;
        assign o_rd_data  = r_s2_data;
    end else begin : g_lat1
        assign o_rd_valid = r_s1_valid;
        assign o_rd_data  = w_s1_data;
    end

endmodule

// File: rtl/memory_banked.sv
// Banked byte memory: BANKS independent lanes, each with its own read
// and write port over a shared RAM/ROM/unmapped address map.
module memory_banked
    import memory_pkg::*;
#(
    parameter  int BANKS       = 2,
    parameter  int RAMADDRBITS = 10,
    parameter  int ROMSIZE     = 2048,
    parameter  int ROMBASE     = 'h4000,
    parameter  int RDLAT       = 1,
    parameter  int BYPASS      = 0,
    localparam int LA          = 16 - $clog2(BANKS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BANKS-1:0][LA-1:0] read_addr,
    input  logic [BANKS-1:0]         read_req,
    output logic [BANKS-1:0][7:0]    read_data,
    output logic [BANKS-1:0]         read_valid,
    input  logic [BANKS-1:0][LA-1:0] write_addr,
    input  logic [BANKS-1:0][7:0]    write_data,
    input  logic [BANKS-1:0]         write_en,
    output logic [BANKS-1:0]         rom_write_err
);

    // Reject configurations the address map cannot represent.
    if (!((BANKS == 1) || (BANKS == 2) || (BANKS == 4) || (BANKS == 8))) begin : g_bad_banks
        $fatal(1, "memory_banked: BANKS must be 1, 2, 4 or 8");
    end
    if ((RDLAT != 1) && (RDLAT != 2)) begin : g_bad_rdlat
        $fatal(1, "memory_banked: RDLAT must be 1 or 2");
    end
    if (((ROMBASE % BANKS) != 0) || ((ROMSIZE % BANKS) != 0)) begin : g_bad_rom_align
        $fatal(1, "memory_banked: ROMBASE and ROMSIZE must be multiples of BANKS");
    end
    if (ROMBASE < (BANKS << RAMADDRBITS)) begin : g_bad_overlap
        $fatal(1, "memory_banked: ROM region overlaps RAM region");
    end
    if ((RAMADDRBITS > LA) || ((ROMBASE + ROMSIZE) > 65536)) begin : g_bad_range
        $fatal(1, "memory_banked: address map exceeds 16-bit byte space");
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_lane
        memory_lane #(
            .BANKS      (BANKS),
            .RAMADDRBITS(RAMADDRBITS),
            .ROMSIZE    (ROMSIZE),
            .ROMBASE    (ROMBASE),
            .RDLAT      (RDLAT),
            .BYPASS     (BYPASS),
            .LANE       (b)
        ) u_lane (
            .clk            (clk),
            .reset          (reset),
            .i_rd_addr      (read_addr[b]),
            .i_rd_req       (read_req[b]),
            .o_rd_data      (read_data[b]),
            .o_rd_valid     (read_valid[b]),
            .i_wr_addr      (write_addr[b]),
            .i_wr_data      (write_data[b]),
            .i_wr_en        (write_en[b]),
            .o_rom_write_err(rom_write_err[b])
        );
    end

endmodule

// File: tb/tb_memory_banked.sv
// Directed bench for memory_banked. Two instances:
//   dut_a: BANKS=2, RDLAT=1, BYPASS=0 (read-first collisions)
//   dut_b: BANKS=4, RDLAT=2, BYPASS=1 (output register, forwarding)
// ROM image byte at offset o is o[7:0] ^ 8'h3C.
module tb_memory_banked;

    localparam int LA_A = 15;
    localparam int LA_B = 14;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic [1:0][LA_A-1:0] a_raddr;
    logic [1:0][LA_A-1:0] a_waddr;
    logic [1:0][7:0]      a_wdata;
    logic [1:0][7:0]      a_rdata;
    logic [1:0]           a_rreq;
    logic [1:0]           a_we;
    logic [1:0]           a_rvalid;
    logic [1:0]           a_err;

    logic [3:0][LA_B-1:0] b_raddr;
    logic [3:0][LA_B-1:0] b_waddr;
    logic [3:0][7:0]      b_wdata;
    logic [3:0][7:0]      b_rdata;
    logic [3:0]           b_rreq;
    logic [3:0]           b_we;
    logic [3:0]           b_rvalid;
    logic [3:0]           b_err;

    int errors = 0;
    int checks = 0;

    memory_banked #(
        .BANKS(2), .RAMADDRBITS(10), .ROMSIZE(2048), .ROMBASE('h4000),
        .RDLAT(1), .BYPASS(0)
    ) dut_a (
        .clk          (clk),
        .reset        (reset),
        .read_addr    (a_raddr),
        .read_req     (a_rreq),
        .read_data    (a_rdata),
        .read_valid   (a_rvalid),
        .write_addr   (a_waddr),
        .write_data   (a_wdata),
        .write_en     (a_we),
        .rom_write_err(a_err)
    );

    memory_banked #(
        .BANKS(4), .RAMADDRBITS(10), .ROMSIZE(2048), .ROMBASE('h4000),
        .RDLAT(2), .BYPASS(1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .read_addr    (b_raddr),
        .read_req     (b_rreq),
        .read_data    (b_rdata),
        .read_valid   (b_rvalid),
        .write_addr   (b_waddr),
        .write_data   (b_wdata),
        .write_en     (b_we),
        .rom_write_err(b_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        a_raddr = '0; a_waddr = '0; a_wdata = '0; a_rreq = '0; a_we = '0;
        b_raddr = '0; b_waddr = '0; b_wdata = '0; b_rreq = '0; b_we = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (3) tick();
        checks++;
        if (a_rvalid !== 2'b00) begin
            errors++; $display("FAIL reset_a_valid: got %b want 00", a_rvalid);
        end
        checks++;
        if (a_rdata !== 16'h0000) begin
            errors++; $display("FAIL reset_a_data: got %h want 0000", a_rdata);
        end
        checks++;
        if (a_err !== 2'b00) begin
            errors++; $display("FAIL reset_a_err: got %b want 00", a_err);
        end
        checks++;
        if ({b_rvalid, b_err} !== 8'h00) begin
            errors++; $display("FAIL reset_b_valid_err: got %b want 00000000", {b_rvalid, b_err});
        end
        checks++;
        if (b_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_b_data: got %h want 00000000", b_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    // Write A5 to byte 0x0011 (lane 1, addr 8), read it next cycle.
    task automatic test_ram_rw();
        a_we = 2'b10; a_waddr[1] = 15'd8; a_wdata[1] = 8'hA5;
        tick();
        a_we = 2'b00; a_rreq = 2'b10; a_raddr[1] = 15'd8;
        tick();
        checks++;
        if (a_rvalid !== 2'b10) begin
            errors++; $display("FAIL ram_rw_valid: got %b want 10", a_rvalid);
        end
        checks++;
        if (a_rdata[1] !== 8'hA5) begin
            errors++; $display("FAIL ram_rw_data: got %h want a5", a_rdata[1]);
        end
        a_rreq = 2'b00;
        tick();
        checks++;
        if (a_rvalid !== 2'b00) begin
            errors++; $display("FAIL ram_rw_idle_valid: got %b want 00", a_rvalid);
        end
        checks++;
        if (a_rdata[1] !== 8'hA5) begin
            errors++; $display("FAIL ram_rw_hold: got %h want a5", a_rdata[1]);
        end
    endtask

    task automatic test_regions();
        // 0x0000 <- 12 (lane0 addr0), 0x07FF <- 77 (lane1 addr 0x3FF, last RAM byte)
        a_we = 2'b11;
        a_waddr[0] = 15'h0000; a_wdata[0] = 8'h12;
        a_waddr[1] = 15'h03FF; a_wdata[1] = 8'h77;
        tick();
        // Unmapped 0x1000 (lane0 addr 0x800) must not alias onto RAM word 0
        a_we = 2'b01; a_waddr[0] = 15'h0800; a_wdata[0] = 8'h99;
        tick();
        checks++;
        if (a_err !== 2'b00) begin
            errors++; $display("FAIL unmapped_write_err: got %b want 00", a_err);
        end
        a_we = 2'b00;
        // 0x4000 -> ROM byte 0 = 3C ; 0x47FF -> ROM byte 0x7FF = C3
        a_rreq = 2'b11; a_raddr[0] = 15'h2000; a_raddr[1] = 15'h23FF;
        tick();
        checks++;
        if (a_rvalid !== 2'b11 || a_rdata !== {8'hC3, 8'h3C}) begin
            errors++; $display("FAIL rom_read: got v=%b d=%h want v=11 d=c33c", a_rvalid, a_rdata);
        end
        // 0x1000 -> FF ; 0x07FF -> 77
        a_raddr[0] = 15'h0800; a_raddr[1] = 15'h03FF;
        tick();
        checks++;
        if (a_rdata !== {8'h77, 8'hFF}) begin
            errors++; $display("FAIL unmapped_and_ram_top: got %h want 77ff", a_rdata);
        end
        // 0x4800 and 0x4801 are past the ROM -> FF
        a_raddr[0] = 15'h2400; a_raddr[1] = 15'h2400;
        tick();
        checks++;
        if (a_rdata !== 16'hFFFF) begin
            errors++; $display("FAIL past_rom_end: got %h want ffff", a_rdata);
        end
        // 0x0000 -> 12 (unaliased) ; 0x0801 (just past RAM) -> FF
        a_raddr[0] = 15'h0000; a_raddr[1] = 15'h0400;
        tick();
        checks++;
        if (a_rdata !== {8'hFF, 8'h12}) begin
            errors++; $display("FAIL ram_boundary: got %h want ff12", a_rdata);
        end
        a_rreq = 2'b00;
        tick();
    endtask

    // Write 00 to ROM byte 0x4002 (lane0 addr 0x2001).
    task automatic test_rom_protect();
        a_we = 2'b01; a_waddr[0] = 15'h2001; a_wdata[0] = 8'h00;
        tick();
        checks++;
        if (a_err !== 2'b01) begin
            errors++; $display("FAIL rom_err_pulse: got %b want 01", a_err);
        end
        a_we = 2'b00;
        tick();
        checks++;
        if (a_err !== 2'b00) begin
            errors++; $display("FAIL rom_err_one_cycle: got %b want 00", a_err);
        end
        a_rreq = 2'b01; a_raddr[0] = 15'h2001;
        tick();
        checks++;
        if (a_rvalid !== 2'b01 || a_rdata[0] !== 8'h3E) begin
            errors++; $display("FAIL rom_unchanged: got v=%b d=%h want v=01 d=3e", a_rvalid, a_rdata[0]);
        end
        a_rreq = 2'b00;
        tick();
    endtask

    // Byte 0x0020 = lane0 addr 0x10 on dut_a; read-first.
    task automatic test_collision_a();
        a_we = 2'b01; a_waddr[0] = 15'h0010; a_wdata[0] = 8'h11;
        tick();
        a_wdata[0] = 8'h22; a_rreq = 2'b01; a_raddr[0] = 15'h0010;
        tick();
        checks++;
        if (a_rdata[0] !== 8'h11) begin
            errors++; $display("FAIL collision_a_old: got %h want 11", a_rdata[0]);
        end
        a_we = 2'b00;
        tick();
        checks++;
        if (a_rdata[0] !== 8'h22) begin
            errors++; $display("FAIL collision_a_after: got %h want 22", a_rdata[0]);
        end
        a_rreq = 2'b00;
        tick();
    endtask

    // Byte 0x0020 = lane0 addr 8 on dut_b; forwarding, 2-cycle latency.
    task automatic test_collision_b();
        b_we = 4'b0001; b_waddr[0] = 14'd8; b_wdata[0] = 8'h11;
        tick();
        b_wdata[0] = 8'h22; b_rreq = 4'b0001; b_raddr[0] = 14'd8;
        tick();
        b_we = 4'b0000;
        tick();
        checks++;
        if (b_rvalid !== 4'b0001 || b_rdata[0] !== 8'h22) begin
            errors++; $display("FAIL collision_b_fwd: got v=%b d=%h want v=0001 d=22", b_rvalid, b_rdata[0]);
        end
        b_rreq = 4'b0000;
        tick();
        checks++;
        if (b_rvalid !== 4'b0001 || b_rdata[0] !== 8'h22) begin
            errors++; $display("FAIL collision_b_after: got v=%b d=%h want v=0001 d=22", b_rvalid, b_rdata[0]);
        end
        // ROM byte 0x4004 (lane0 addr 0x1001): write+read same cycle, no forwarding
        b_we = 4'b0001; b_waddr[0] = 14'h1001; b_wdata[0] = 8'h00;
        b_rreq = 4'b0001; b_raddr[0] = 14'h1001;
        tick();
        b_we = 4'b0000; b_rreq = 4'b0000;
        checks++;
        if (b_err !== 4'b0001) begin
            errors++; $display("FAIL collision_b_rom_err: got %b want 0001", b_err);
        end
        tick();
        checks++;
        if (b_rvalid !== 4'b0001 || b_rdata[0] !== 8'h38) begin
            errors++; $display("FAIL collision_b_rom_nofwd: got v=%b d=%h want v=0001 d=38", b_rvalid, b_rdata[0]);
        end
        tick();
    endtask

    // All four lanes, eight consecutive reads, RDLAT=2.
    task automatic test_back_to_back();
        logic [3:0][7:0] exp_d;
        logic [3:0]      exp_v;
        for (int i = 0; i < 8; i++) begin
            b_we = 4'hF;
            for (int l = 0; l < 4; l++) begin
                b_waddr[l] = 14'(i);
                b_wdata[l] = 8'(i * 16 + l + 1);
            end
            tick();
        end
        b_we = 4'h0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                b_rreq = 4'hF;
                for (int l = 0; l < 4; l++) b_raddr[l] = 14'(k);
            end else begin
                b_rreq = 4'h0;
            end
            tick();
            exp_v = (k >= 1 && k <= 8) ? 4'hF : 4'h0;
            checks++;
            if (b_rvalid !== exp_v) begin
                errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, b_rvalid, exp_v);
            end
            if (k >= 1 && k <= 8) begin
                for (int l = 0; l < 4; l++) exp_d[l] = 8'((k - 1) * 16 + l + 1);
                checks++;
                if (b_rdata !== exp_d) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, b_rdata, exp_d);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        b_rreq = 4'hF;
        for (int l = 0; l < 4; l++) b_raddr[l] = 14'd1;
        tick();
        for (int l = 0; l < 4; l++) b_raddr[l] = 14'd2;
        tick();
        // Reset with reads in flight, plus a RAM write and a ROM write that must be ignored
        reset = 1'b1;
        for (int l = 0; l < 4; l++) b_raddr[l] = 14'd3;
        b_we = 4'b0011;
        b_waddr[0] = 14'h0000; b_wdata[0] = 8'hEE;
        b_waddr[1] = 14'h1001; b_wdata[1] = 8'h00;
        tick();
        checks++;
        if (b_rvalid !== 4'h0 || b_err !== 4'h0 || b_rdata !== 32'h0) begin
            errors++; $display("FAIL midreset_outputs: got v=%b e=%b d=%h want all zero", b_rvalid, b_err, b_rdata);
        end
        b_we = 4'h0; b_rreq = 4'h0;
        tick();
        checks++;
        if (b_rvalid !== 4'h0 || b_rdata !== 32'h0) begin
            errors++; $display("FAIL midreset_hold: got v=%b d=%h want zero", b_rvalid, b_rdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (b_rvalid !== 4'h0) begin
            errors++; $display("FAIL midreset_no_late_valid: got %b want 0000", b_rvalid);
        end
        // Byte 0 (lane0 addr0) still 01; byte 5 (lane1 addr1) still 12
        b_rreq = 4'b0011; b_raddr[0] = 14'd0; b_raddr[1] = 14'd1;
        tick();
        b_rreq = 4'b0000;
        tick();
        checks++;
        if (b_rvalid !== 4'b0011 || b_rdata[0] !== 8'h01 || b_rdata[1] !== 8'h12) begin
            errors++; $display("FAIL midreset_ram_intact: got v=%b d0=%h d1=%h want v=0011 d0=01 d1=12",
                               b_rvalid, b_rdata[0], b_rdata[1]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_regions();
        test_rom_protect();
        test_collision_a();
        test_collision_b();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
